ec_stripe_sequencer: RTL and testbench

Multi-lane successor to the erasure-coding control block. It sequences a full stripe encode across ceil(M/LANES) passes. Each pass fetches up to LANES bitmatrix rows, streams K input words per packet from the input-buffer FIFO into the engine, drains the engine, and writes LANES parity results to the output buffer. It sits between the register block, input FIFO, bitmatrix memory, engine and output buffer, and replaces the single-pass engine FSM.

---
 rtl/ec_stripe_sequencer.sv | 221 ++++++++++++++++++++++
 tb/tb_ec_stripe_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ec_stripe_sequencer.sv
// Stripe-level erasure-coding sequencer: fetches LANES bitmatrix rows per pass, streams K words per packet, writes lane results.
// Optional `ECA_STALL_CNT_EN adds the stall_cnt output counting FIFO-empty and output-full stall cycles.
module ec_stripe_sequencer #(
    parameter int K_MAX     = 128,
    parameter int M_MAX     = 128,
    parameter int LANES     = 4,
    parameter int PKT_W     = 16,
    parameter int BM_ADDR_W = $clog2(M_MAX),
    parameter int K_W       = $clog2(K_MAX + 1),
    parameter int M_W       = $clog2(M_MAX + 1),
    localparam int LN_W     = $clog2(LANES) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [K_W-1:0]       k_cfg,
    input  logic [M_W-1:0]       m_cfg,
    input  logic [PKT_W-1:0]     pkt_num,
    input  logic                 inbuf_fifo_empty,
    output logic                 inbuf_fifo_rd_rq,
    output logic                 bm_rd_rq,
    output logic [BM_ADDR_W-1:0] bm_rd_addr,
    input  logic                 bm_rd_data_val,
    output logic                 eng_bm_load,
    output logic [LN_W-1:0]      eng_bm_lane,
    output logic                 eng_calc_en,
    input  logic                 eng_data_used,
    input  logic                 eng_empty,
    output logic                 eng_clr,
    input  logic                 outbuf_full,
    output logic                 outbuf_wr_en,
    output logic [LN_W-1:0]      outbuf_lane,
    output logic                 busy,
    output logic                 done,
    output logic                 err_cfg,
    output logic                 stat_wr_en
`ifdef ECA_STALL_CNT_EN
    ,
    output logic [31:0]          stall_cnt
`endif
);

    typedef enum logic [3:0] {
        S_IDLE, S_CHECK, S_BM_FETCH, S_BM_WAIT, S_RUN,
        S_RUN_WAIT, S_DRAIN, S_WRITE, S_NEXT, S_DONE
    } state_t;

    state_t           state, state_n;
    logic [LN_W-1:0]  lane, lane_n;
    logic [K_W-1:0]   words, words_n;
    logic [PKT_W-1:0] pkt, pkt_n;
    logic [M_W-1:0]   row_base, row_base_n;   // pass * LANES, kept as a running sum
    logic             err_n;

    logic [M_W-1:0]   rem, lanes_act;
    logic             last_lane, more_pass, cfg_bad, start_ok;

    assign rem       = m_cfg - row_base;
    assign lanes_act = (rem > M_W'(LANES)) ? M_W'(LANES) : rem;
    assign last_lane = (M_W'(lane) + M_W'(1)) == lanes_act;
    // One extra bit so the next-pass base never wraps when M is near its maximum
    assign more_pass = ({1'b0, row_base} + (M_W+1)'(LANES)) < {1'b0, m_cfg};
    assign cfg_bad   = (32'(k_cfg) < 2) || (32'(k_cfg) > K_MAX) ||
                       (32'(m_cfg) < 2) || (32'(m_cfg) > M_MAX) || (pkt_num == '0);
    assign start_ok  = (state == S_IDLE) && start && !abort;
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            lane     <= '0;
            words    <= '0;
            pkt      <= '0;
            row_base <= '0;
            err_cfg  <= 1'b0;
        end else begin
            state    <= state_n;
            lane     <= lane_n;
            words    <= words_n;
            pkt      <= pkt_n;
            row_base <= row_base_n;
            err_cfg  <= err_n;
        end
    end

    always_comb begin
        state_n          = state;
        lane_n           = lane;
        words_n          = words;
        pkt_n            = pkt;
        row_base_n       = row_base;
        err_n            = err_cfg;
        inbuf_fifo_rd_rq = 1'b0;
        bm_rd_rq         = 1'b0;
        bm_rd_addr       = BM_ADDR_W'(row_base + M_W'(lane));
        eng_bm_load      = 1'b0;
        eng_bm_lane      = '0;
        eng_calc_en      = 1'b0;
        eng_clr          = 1'b0;
        outbuf_wr_en     = 1'b0;
        outbuf_lane      = '0;
        done             = 1'b0;
        stat_wr_en       = 1'b0;

        case (state)
            S_IDLE: begin
                if (start_ok) begin
                    err_n   = 1'b0;
                    state_n = S_CHECK;
                end
            end
            S_CHECK: begin
                if (cfg_bad) begin
                    err_n   = 1'b1;
                    state_n = S_DONE;
                end else begin
                    row_base_n = '0;
                    pkt_n      = '0;
                    lane_n     = '0;
                    words_n    = '0;
                    state_n    = S_BM_FETCH;
                end
            end
            S_BM_FETCH: begin
                bm_rd_rq = 1'b1;
                state_n  = S_BM_WAIT;
            end
            S_BM_WAIT: begin
                if (bm_rd_data_val) begin
                    eng_bm_load = 1'b1;
                    eng_bm_lane = lane;
                    if (last_lane) begin
                        eng_clr = 1'b1;
                        state_n = S_RUN;
                    end else begin
                        lane_n  = lane + LN_W'(1);
                        state_n = S_BM_FETCH;
                    end
                end
            end
            S_RUN: begin
                eng_calc_en = 1'b1;
                if (!inbuf_fifo_empty) begin
                    inbuf_fifo_rd_rq = 1'b1;
                    words_n          = words + K_W'(1);
                    state_n          = S_RUN_WAIT;
                end
            end
            S_RUN_WAIT: begin
                eng_calc_en = 1'b1;
                if (eng_data_used)
                    state_n = (words == k_cfg) ? S_DRAIN : S_RUN;
            end
            S_DRAIN: begin
                eng_calc_en = 1'b1;
                if (eng_empty) begin
                    lane_n  = '0;
                    words_n = '0;
                    state_n = S_WRITE;
                end
            end
            S_WRITE: begin
                if (!outbuf_full) begin
                    outbuf_wr_en = 1'b1;
                    outbuf_lane  = lane;
                    lane_n       = lane + LN_W'(1);
                    if (last_lane)
                        state_n = S_NEXT;
                end
            end
            S_NEXT: begin
                // Rows already held by the engine are reused for every packet of a pass
                if ((pkt + PKT_W'(1)) < pkt_num) begin
                    pkt_n   = pkt + PKT_W'(1);
                    eng_clr = 1'b1;
                    state_n = S_RUN;
                end else if (more_pass) begin
                    row_base_n = row_base + M_W'(LANES);
                    pkt_n      = '0;
                    lane_n     = '0;
                    state_n    = S_BM_FETCH;
                end else begin
                    state_n = S_DONE;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                stat_wr_en = 1'b1;
                state_n    = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase

        // Abort wins over everything outside IDLE, including a pending done
        if (abort && (state != S_IDLE)) begin
            state_n          = S_IDLE;
            inbuf_fifo_rd_rq = 1'b0;
            bm_rd_rq         = 1'b0;
            eng_bm_load      = 1'b0;
            eng_calc_en      = 1'b0;
            outbuf_wr_en     = 1'b0;
            done             = 1'b0;
            stat_wr_en       = 1'b0;
            eng_clr          = 1'b1;
        end
    end

`ifdef ECA_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (start_ok)
            stall_cnt <= '0;
        else if (((state == S_RUN && inbuf_fifo_empty) || (state == S_WRITE && outbuf_full)) &&
                 (stall_cnt != '1))
            stall_cnt <= stall_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_ec_stripe_sequencer.sv
// Bench for ec_stripe_sequencer: reactive environment plus a stripe-level reference model of reads, pops and writes.
module tb_ec_stripe_sequencer;
    localparam int LANES     = 4;
    localparam int K_MAX     = 128;
    localparam int M_MAX     = 128;
    localparam int PKT_W     = 16;
    localparam int BM_ADDR_W = $clog2(M_MAX);
    localparam int K_W       = $clog2(K_MAX + 1);
    localparam int M_W       = $clog2(M_MAX + 1);
    localparam int LN_W      = $clog2(LANES) + 1;

    logic                 clk = 1'b0;
    logic                 rst, start, abort;
    logic [K_W-1:0]       k_cfg;
    logic [M_W-1:0]       m_cfg;
    logic [PKT_W-1:0]     pkt_num;
    logic                 inbuf_fifo_empty, inbuf_fifo_rd_rq;
    logic                 bm_rd_rq, bm_rd_data_val;
    logic [BM_ADDR_W-1:0] bm_rd_addr;
    logic                 eng_bm_load, eng_calc_en, eng_data_used, eng_empty, eng_clr;
    logic [LN_W-1:0]      eng_bm_lane, outbuf_lane;
    logic                 outbuf_full, outbuf_wr_en;
    logic                 busy, done, err_cfg, stat_wr_en;
`ifdef ECA_STALL_CNT_EN
    logic [31:0]          stall_cnt;
`endif

    ec_stripe_sequencer #(
        .K_MAX(K_MAX), .M_MAX(M_MAX), .LANES(LANES), .PKT_W(PKT_W),
        .BM_ADDR_W(BM_ADDR_W), .K_W(K_W), .M_W(M_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .k_cfg(k_cfg), .m_cfg(m_cfg), .pkt_num(pkt_num),
        .inbuf_fifo_empty(inbuf_fifo_empty), .inbuf_fifo_rd_rq(inbuf_fifo_rd_rq),
        .bm_rd_rq(bm_rd_rq), .bm_rd_addr(bm_rd_addr), .bm_rd_data_val(bm_rd_data_val),
        .eng_bm_load(eng_bm_load), .eng_bm_lane(eng_bm_lane), .eng_calc_en(eng_calc_en),
        .eng_data_used(eng_data_used), .eng_empty(eng_empty), .eng_clr(eng_clr),
        .outbuf_full(outbuf_full), .outbuf_wr_en(outbuf_wr_en), .outbuf_lane(outbuf_lane),
        .busy(busy), .done(done), .err_cfg(err_cfg), .stat_wr_en(stat_wr_en)
`ifdef ECA_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    bit   rnd_env = 1'b0;
    logic dir_empty = 1'b0, dir_full = 1'b0;
    logic env_empty = 1'b0, env_full = 1'b0;
    assign inbuf_fifo_empty = rnd_env ? env_empty : dir_empty;
    assign outbuf_full      = rnd_env ? env_full  : dir_full;

    int obs_addr[$], obs_load[$], obs_wl[$];
    int n_pop = 0, n_done = 0, n_viol = 0;
    int bm_pend = 0, used_pend = 0;

    // Environment: inputs change just after negedge, outputs are recorded once settled
    always @(negedge clk) begin
        bm_rd_data_val = (bm_pend == 1);
        if (bm_pend > 0) bm_pend--;
        eng_data_used = (used_pend == 1);
        if (used_pend > 0) used_pend--;
        eng_empty = rnd_env ? ($urandom_range(1, 0) == 1) : 1'b1;
        env_empty = ($urandom_range(3, 0) == 0);
        env_full  = ($urandom_range(3, 0) == 0);
        #3;
        if (!rst) begin
            if (bm_rd_rq) obs_addr.push_back(int'(bm_rd_addr));
            if (eng_bm_load) obs_load.push_back(int'(eng_bm_lane));
            if (inbuf_fifo_rd_rq) n_pop++;
            if (outbuf_wr_en) begin
                obs_wl.push_back(int'(outbuf_lane));
                if (outbuf_full) n_viol++;
            end
            if (done) n_done++;
            if (done !== stat_wr_en) n_viol++;
        end
        if (bm_rd_rq) bm_pend = rnd_env ? int'($urandom_range(3, 1)) : 1;
        if (inbuf_fifo_rd_rq) used_pend = rnd_env ? int'($urandom_range(3, 1)) : 1;
    end

    int exp_addr[$], exp_load[$], exp_wl[$];
    int exp_pops;
    int ba, bl, bw, bp, bd, bv;

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic build_model(input int k, input int m, input int p);
        int npass, la;
        exp_addr.delete();
        exp_load.delete();
        exp_wl.delete();
        npass = (m + LANES - 1) / LANES;
        for (int ps = 0; ps < npass; ps++) begin
            la = (m - ps * LANES < LANES) ? (m - ps * LANES) : LANES;
            for (int l = 0; l < la; l++) begin
                exp_addr.push_back(ps * LANES + l);
                exp_load.push_back(l);
            end
            for (int pk = 0; pk < p; pk++)
                for (int l = 0; l < la; l++) exp_wl.push_back(l);
        end
        exp_pops = k * p * npass;
    endtask

    task automatic snap();
        ba = obs_addr.size();
        bl = obs_load.size();
        bw = obs_wl.size();
        bp = n_pop;
        bd = n_done;
        bv = n_viol;
    endtask

    task automatic wait_done(input int budget, output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < budget) begin
            tick();
            cyc++;
        end
        chk("done_seen", done, 1);
        chk("stat_wr_en_with_done", stat_wr_en, 1);
        tick();
        chk("busy_after_done", busy, 0);
        chk("done_single_cycle", done, 0);
    endtask

    task automatic compare(input string tag);
        chk($sformatf("%s bm_reads", tag), obs_addr.size() - ba, exp_addr.size());
        foreach (exp_addr[i])
            if (ba + i < obs_addr.size())
                chk($sformatf("%s bm_addr[%0d]", tag, i), obs_addr[ba + i], exp_addr[i]);
        chk($sformatf("%s bm_loads", tag), obs_load.size() - bl, exp_load.size());
        foreach (exp_load[i])
            if (bl + i < obs_load.size())
                chk($sformatf("%s load_lane[%0d]", tag, i), obs_load[bl + i], exp_load[i]);
        chk($sformatf("%s writes", tag), obs_wl.size() - bw, exp_wl.size());
        foreach (exp_wl[i])
            if (bw + i < obs_wl.size())
                chk($sformatf("%s wr_lane[%0d]", tag, i), obs_wl[bw + i], exp_wl[i]);
        chk($sformatf("%s pops", tag), n_pop - bp, exp_pops);
        chk($sformatf("%s done_count", tag), n_done - bd, 1);
        chk($sformatf("%s protocol", tag), n_viol - bv, 0);
    endtask

    task automatic run_stripe(input int k, input int m, input int p, input bit restart);
        int cyc;
        build_model(k, m, p);
        k_cfg   = K_W'(k);
        m_cfg   = M_W'(m);
        pkt_num = PKT_W'(p);
        snap();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("err_cleared_on_start", err_cfg, 0);
        if (restart) begin
            repeat (4) tick();
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        wait_done(5000, cyc);
        chk("err_cfg_good_cfg", err_cfg, 0);
    endtask

    task automatic err_case(input int k, input int m, input int p, input string tag);
        int cyc;
        k_cfg   = K_W'(k);
        m_cfg   = M_W'(m);
        pkt_num = PKT_W'(p);
        snap();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(10, cyc);
        chk($sformatf("%s done_latency_ok", tag), (cyc <= 3), 1);
        chk($sformatf("%s err_cfg", tag), err_cfg, 1);
        chk($sformatf("%s pops", tag), n_pop - bp, 0);
        chk($sformatf("%s bm_reads", tag), obs_addr.size() - ba, 0);
        chk($sformatf("%s done_count", tag), n_done - bd, 1);
    endtask

    initial begin
        int cyc, k, m, p;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        k_cfg = '0; m_cfg = '0; pkt_num = '0;
        repeat (3) tick();
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst err_cfg", err_cfg, 0);
        chk("rst outputs", {inbuf_fifo_rd_rq, bm_rd_rq, eng_bm_load, eng_calc_en,
                            eng_clr, outbuf_wr_en, stat_wr_en}, 0);
`ifdef ECA_STALL_CNT_EN
        chk("rst stall_cnt", stall_cnt, 0);
`endif
        rst = 1'b0;
        tick();

        run_stripe(4, 4, 1, 0);
        compare("k4m4p1");
        run_stripe(3, 6, 2, 0);
        compare("k3m6p2");
        run_stripe(K_MAX, 2, 1, 0);
        compare("kmax");
        run_stripe(2, M_MAX, 1, 0);
        compare("mmax");
        run_stripe(2, 5, 1, 0);
        compare("m5_single_tail");

        err_case(1, 4, 1, "k1");
        err_case(4, 4, 0, "pkt0");
        err_case(4, 1, 1, "m1");
        err_case(K_MAX + 1, 4, 1, "k_over");

        // Controlled stalls: 10 RUN cycles with empty FIFO, 5 WRITE cycles with full buffer
        rnd_env = 1'b0; dir_empty = 1'b1; dir_full = 1'b0;
        build_model(2, 4, 1);
        k_cfg = K_W'(2); m_cfg = M_W'(4); pkt_num = PKT_W'(1);
        snap();
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        while (eng_clr !== 1'b1 && cyc < 200) begin tick(); cyc++; end
        chk("stall reach_run", eng_clr, 1);
        repeat (11) tick();
        chk("stall no_pop_while_empty", n_pop - bp, 0);
        dir_empty = 1'b0;
        cyc = 0;
        while (outbuf_wr_en !== 1'b1 && cyc < 200) begin tick(); cyc++; end
        chk("stall reach_write", outbuf_wr_en, 1);
        tick();
        dir_full = 1'b1;
        repeat (5) tick();
        chk("stall no_write_while_full", obs_wl.size() - bw, 1);
        dir_full = 1'b0;
        wait_done(200, cyc);
`ifdef ECA_STALL_CNT_EN
        chk("stall_cnt_at_done", stall_cnt, 15);
`endif
        compare("stall");

        // Abort after two pops, then a full stripe must still work
        k_cfg = K_W'(4); m_cfg = M_W'(4); pkt_num = PKT_W'(1);
        snap();
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        while (n_pop - bp < 2 && cyc < 200) begin tick(); cyc++; end
        chk("abort two_pops", n_pop - bp, 2);
        abort = 1'b1;
        #1;
        chk("abort eng_clr", eng_clr, 1);
        chk("abort requests_low", {inbuf_fifo_rd_rq, bm_rd_rq, eng_calc_en, outbuf_wr_en}, 0);
        tick();
        abort = 1'b0;
        chk("abort busy_low", busy, 0);
        chk("abort clr_one_cycle", eng_clr, 0);
        repeat (8) tick();
        chk("abort no_done", n_done - bd, 0);
        chk("abort pops_frozen", n_pop - bp, 2);
        run_stripe(4, 4, 1, 0);
        compare("after_abort");

        // start together with abort in IDLE is dropped
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("start_abort_idle busy", busy, 0);
        tick();
        chk("start_abort_idle stays_idle", busy, 0);

        rnd_env = 1'b1;
        for (int it = 0; it < 8; it++) begin
            k = int'($urandom_range(8, 2));
            m = int'($urandom_range(11, 2));
            p = int'($urandom_range(3, 1));
            run_stripe(k, m, p, (it % 2) == 1);
            compare($sformatf("rnd%0d_k%0d_m%0d_p%0d", it, k, m, p));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
